// File: rtl/elevator_door_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_door_ctrl
//
// Car door sequencer sitting downstream of the motion/floor controller. It
// opens the door when the car arrives at a floor (or the cabin open button is
// pressed while the car is parked). It holds the door open for a fixed number
// of time-base ticks and then closes it again. It reports door_closed back to
// the controller as the motion interlock.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   arrive         one-cycle pulse, car has stopped at a floor
//   moving         car in motion, blocks door opening from CLOSED
//   bt_door_open   cabin open button (level, synchronous)
//   bt_door_close  cabin close button (level, synchronous)
//   led_door[7:0]  door bargraph, FF closed .. 00 fully open
//   led_open[4:0]  thermometer of remaining hold ticks (OPEN_HOLD only)
//   tick_led       toggles on every time-base tick
//   st[3:0]        state code: 0 CLOSED, 1 OPENING, 2 OPEN_HOLD, 3 CLOSING
//   door_closed    high only in CLOSED
//   req_clr        one-cycle pulse when an opening is accepted from CLOSED
// -----------------------------------------------------------------------------
module elevator_door_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int HOLD_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arrive,
    input  logic       moving,
    input  logic       bt_door_open,
    input  logic       bt_door_close,
    output logic [7:0] led_door,
    output logic [4:0] led_open,
    output logic       tick_led,
    output logic [3:0] st,
    output logic       door_closed,
    output logic       req_clr
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0]    HOLD_LOAD  = 3'(HOLD_TICKS);

    typedef enum logic [1:0] {
        CLOSED    = 2'd0,
        OPENING   = 2'd1,
        OPEN_HOLD = 2'd2,
        CLOSING   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    pos_q, pos_d;
    logic [2:0]    hold_q, hold_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          reqClr_d;
    logic          clrPresc;
    logic          tick;

    logic          tickLed_q;
    logic [7:0]    ledDoor_q;
    logic [4:0]    ledOpen_q;
    logic [3:0]    st_q;
    logic          doorClosed_q;
    logic          reqClr_q;

    // Door opens from the centre outwards, so the bargraph clears from the
    // middle bits first.
    function automatic logic [7:0] doorMap(input logic [2:0] pos);
        case (pos)
            3'd0:    doorMap = 8'hFF;
            3'd1:    doorMap = 8'hE7;
            3'd2:    doorMap = 8'hC3;
            3'd3:    doorMap = 8'h81;
            default: doorMap = 8'h00;
        endcase
    endfunction

    // hold = n lights the lowest n bits.
    function automatic logic [4:0] holdTherm(input logic [2:0] hold);
        case (hold)
            3'd0:    holdTherm = 5'b00000;
            3'd1:    holdTherm = 5'b00001;
            3'd2:    holdTherm = 5'b00011;
            3'd3:    holdTherm = 5'b00111;
            3'd4:    holdTherm = 5'b01111;
            default: holdTherm = 5'b11111;
        endcase
    endfunction

    assign tick = (presc_q == PRESC_LAST);

    // Next-state logic. An open request in OPEN_HOLD/CLOSING has priority
    // over a coincident tick, so the door never steps while it is reversed
    // or while the hold is being extended.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hold_d   = hold_q;
        reqClr_d = 1'b0;
        clrPresc = 1'b0;

        case (state_q)
            CLOSED: begin
                if (!moving && (arrive || bt_door_open)) begin
                    state_d  = OPENING;
                    reqClr_d = 1'b1;
                end
            end
            OPENING: begin
                if (tick) begin
                    pos_d = pos_q + 3'd1;
                    if (pos_q == 3'd3) begin
                        state_d = OPEN_HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            OPEN_HOLD: begin
                if (bt_door_open) begin
                    hold_d   = HOLD_LOAD;
                    clrPresc = 1'b1;
                end else if (bt_door_close) begin
                    state_d = CLOSING;
                    hold_d  = 3'd0;
                end else if (tick) begin
                    hold_d = hold_q - 3'd1;
                    if (hold_q == 3'd1) begin
                        state_d = CLOSING;
                    end
                end
            end
            CLOSING: begin
                if (bt_door_open || arrive) begin
                    state_d = OPENING;
                end else if (tick) begin
                    pos_d = pos_q - 3'd1;
                    if (pos_q == 3'd1) begin
                        state_d = CLOSED;
                    end
                end
            end
            default: begin
                state_d = CLOSED;
            end
        endcase

        // Restarting the prescaler on every state change keeps each state's
        // first tick exactly TICK_DIV cycles after entry.
        if (tick || clrPresc || (state_d != state_q)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLOSED;
            pos_q   <= 3'd0;
            hold_q  <= 3'd0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
            presc_q <= presc_d;
        end
    end

    // Outputs are registered from the next-state values so that they change
    // on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tickLed_q    <= 1'b0;
            ledDoor_q    <= 8'hFF;
            ledOpen_q    <= 5'd0;
            st_q         <= 4'd0;
            doorClosed_q <= 1'b1;
            reqClr_q     <= 1'b0;
        end else begin
            tickLed_q    <= tickLed_q ^ tick;
            ledDoor_q    <= doorMap(pos_d);
            ledOpen_q    <= (state_d == OPEN_HOLD) ? holdTherm(hold_d) : 5'd0;
            st_q         <= {2'b00, state_d};
            doorClosed_q <= (state_d == CLOSED);
            reqClr_q     <= reqClr_d;
        end
    end

    assign led_door    = ledDoor_q;
    assign led_open    = ledOpen_q;
    assign tick_led    = tickLed_q;
    assign st          = st_q;
    assign door_closed = doorClosed_q;
    assign req_clr     = reqClr_q;

endmodule

// File: doc/elevator_door_ctrl.md
Name: elevator_door_ctrl

Overview:
- Car door sequencer. Sits downstream of the motion/floor controller: consumes its "car stopped at floor" pulse plus the cabin door buttons.
- Drives the door LED bargraph (led_door), the hold-time display (led_open) and the time-base LED.
- Returns door_closed (motion interlock) and req_clr (request-register clear) to the controller.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per door time-base tick (bench uses 4); must be >=2.
- HOLD_TICKS, 5, ticks the door stays fully open; range 1..5; sets the initial led_open fill.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- arrive  in  1  one-cycle pulse: car has stopped at a floor.
- moving  in  1  car in motion; blocks door opening.
- bt_door_open  in  1  cabin open button, level, synchronous.
- bt_door_close  in  1  cabin close button, level, synchronous.
- led_door  out  8  door bargraph: FF closed, 00 fully open.
- led_open  out  5  thermometer of remaining hold ticks.
- tick_led  out  1  toggles on every time-base tick.
- st  out  4  state code: 0 CLOSED, 1 OPENING, 2 OPEN_HOLD, 3 CLOSING.
- door_closed  out  1  high only in CLOSED.
- req_clr  out  1  one-cycle pulse when a door opening is accepted from CLOSED.

Behaviour:
- Reset (rst=0, async) values:
  - state CLOSED, door position pos=0, hold count=0, prescaler=0.
  - led_door=8'hFF, led_open=0, tick_led=0, st=0, door_closed=1, req_clr=0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick is asserted in the cycle where it equals TICK_DIV-1, then it wraps to 0.
  - Cleared to 0 on every state change, so each state's tick timing is exact.
  - tick_led toggles on each tick.
- pos is 0..4. led_door map: 0=FF, 1=E7, 2=C3, 3=81, 4=00 (door opens from the centre).
- CLOSED:
  - arrive=1, or bt_door_open=1 with moving=0 → OPENING next edge; req_clr=1 for exactly that cycle.
  - arrive while moving=1 is ignored.
  - Nothing else leaves CLOSED.
- OPENING:
  - Each tick: pos+1.
  - On the tick where pos goes 3→4 → OPEN_HOLD, load hold=HOLD_TICKS.
  - Buttons are ignored.
- OPEN_HOLD:
  - Each tick: hold-1; when hold reaches 0 → CLOSING.
  - bt_door_open=1 → reload hold=HOLD_TICKS and clear the prescaler; stay in OPEN_HOLD.
  - bt_door_close=1 with bt_door_open=0 → CLOSING next edge.
  - Open and close pressed together: open wins.
  - arrive is ignored.
- CLOSING:
  - Each tick: pos-1; when pos reaches 0 → CLOSED.
  - bt_door_open=1 or arrive=1 → OPENING next edge; pos is kept, no jump; req_clr is not pulsed.
  - bt_door_close is ignored.
- led_open:
  - Thermometer of hold: hold=n → the lowest n bits set (5→1F, 3→07, 0→00).
  - Forced 0 outside OPEN_HOLD.
- Latency from arrive accepted at edge E0 (TICK_DIV=T, HOLD_TICKS=H):
  - pos1 at E0+T; OPEN_HOLD at E0+4T.
  - CLOSING at E0+4T+HT; CLOSED at E0+8T+HT.
- All outputs are registered. door_closed deasserts on the same edge st leaves 0.
- rst asserted mid-operation → immediate reset values (door reported closed). The controller re-issues arrive if needed.

Test Plan:
1. Reset/idle: rst low 170 ns then high, no inputs → led_door=FF, st=0, door_closed=1, led_open=0, req_clr never pulses.
2. Full cycle (TICK_DIV=4, HOLD_TICKS=5): arrive pulse at edge E0 →
   - req_clr high one cycle; led_door FF→E7→C3→81→00 at E0+4/8/12/16.
   - led_open 1F at E0+16, stepping down to 00; st=3 at E0+36.
   - led_door back to FF and st=0 at E0+52.
3. Hold extend: during OPEN_HOLD at led_open=03, press bt_door_open one cycle → led_open=1F, closing delayed by 20 cycles from the press.
4. Early close: in OPEN_HOLD press bt_door_close one cycle → st=3 next edge, led_open=00, door closed 16 cycles later.
5. Reopen while closing: at led_door=C3 in CLOSING press bt_door_open → st=1 next edge, led_door C3→81→00, no req_clr pulse. Pressing open+close together in OPEN_HOLD → stays in hold, count reloaded.
6. Interlocks: arrive or bt_door_open with moving=1 in CLOSED → no change. Assert rst at led_door=81 → async return to FF/st=0/door_closed=1 within the reset cycle.
